pic_interrupt_sequencer: RTL and testbench

- Control sequencer for the 8259A interrupt path. Decides when the highest pending request may interrupt the CPU, raises INT, and runs the two-pulse INTA acknowledge cycle.
- On acknowledge it commands the in-service register to latch the acknowledged level, then drives the vector byte.
- Decodes OCW2 writes into end-of-interrupt pulses and priority-rotation updates for the in-service register and priority resolver.
- Sits between the IRR/priority resolver, the in-service register and the bus/control interface.

---
 rtl/pic_interrupt_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pic_interrupt_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pic_interrupt_sequencer.sv
// 8259A interrupt sequencer: INT request, two-pulse INTA acknowledge, OCW2 EOI/rotation decode.
// Optional AUTO_EOI_EN: automatic EOI (and rotate-in-AEOI) one cycle after the vector is driven.
module pic_interrupt_sequencer #(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] request_highest,
  input  logic [NUM_IR-1:0] highest_level_in_service,
  input  logic              inta_pulse,
  input  logic              ocw2_write,
  input  logic [7:0]        ocw2_data,
  input  logic [4:0]        vector_base,
  output logic              int_out,
  output logic [NUM_IR-1:0] interrupt,
  output logic              latch_ISR,
  output logic [NUM_IR-1:0] clear_irr,
  output logic [NUM_IR-1:0] end_interrupt,
  output logic [2:0]        priority_rotate,
  output logic [7:0]        data_out,
  output logic              data_out_en
);

  // state | meaning
  // IDLE  | waiting for a request that beats the in-service level
  // REQ   | INT raised, waiting for first INTA
  // ACK1  | level latched, waiting for second INTA to drive the vector
  typedef enum logic [1:0] {IDLE, REQ, ACK1} state_t;

  state_t            state, state_next;
  logic [NUM_IR-1:0] acked, acked_next;
  logic [NUM_IR-1:0] interrupt_next, clear_irr_next, end_interrupt_next;
  logic              latch_next, data_out_en_next;
  logic [7:0]        data_out_next;
  logic [2:0]        rotate_next;
  logic [2:0]        acked_level;
  logic              win;
  logic              unused_ocw2_bits;

  function automatic logic [2:0] level_of(input logic [NUM_IR-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_IR; i++)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] rank_of(input logic [NUM_IR-1:0] v, input logic [2:0] rot);
    return level_of(v) - rot - 3'd1;
  endfunction

  assign unused_ocw2_bits = ^ocw2_data[4:3];
  assign int_out          = (state == REQ);
  // A withdrawn request (spurious cycle) reports level 7.
  assign acked_level      = (acked == '0) ? 3'd7 : level_of(acked);
  assign win = (request_highest != '0) &&
               ((highest_level_in_service == '0) ||
                (rank_of(request_highest, priority_rotate) <
                 rank_of(highest_level_in_service, priority_rotate)));

`ifdef AUTO_EOI_EN
  logic aeoi_due, aeoi_due_next;
  logic aeoi_rotate, aeoi_rotate_next;
`endif

  always_comb begin
    state_next         = state;
    acked_next         = acked;
    latch_next         = 1'b0;
    interrupt_next     = '0;
    clear_irr_next     = '0;
    data_out_next      = '0;
    data_out_en_next   = 1'b0;
    end_interrupt_next = '0;
    rotate_next        = priority_rotate;
`ifdef AUTO_EOI_EN
    aeoi_due_next    = 1'b0;
    aeoi_rotate_next = aeoi_rotate;
`endif

    case (state)
      IDLE: if (win) state_next = REQ;
      REQ: if (inta_pulse) begin
        acked_next     = request_highest;
        latch_next     = (request_highest != '0);
        interrupt_next = request_highest;
        clear_irr_next = request_highest;
        state_next     = ACK1;
      end
      ACK1: if (inta_pulse) begin
        data_out_next    = {vector_base, acked_level};
        data_out_en_next = 1'b1;
        state_next       = IDLE;
`ifdef AUTO_EOI_EN
        aeoi_due_next    = 1'b1;
`endif
      end
      default: state_next = IDLE;
    endcase

`ifdef AUTO_EOI_EN
    // Automatic EOI first, so an explicit OCW2 rotation in the same cycle wins.
    if (aeoi_due) begin
      end_interrupt_next = acked;
      if (aeoi_rotate && acked != '0) rotate_next = acked_level;
    end
`endif

    if (ocw2_write) begin
      case (ocw2_data[7:5])
        3'b001: end_interrupt_next = end_interrupt_next | highest_level_in_service;
        3'b011: end_interrupt_next = end_interrupt_next | (NUM_IR'(1) << ocw2_data[2:0]);
        3'b101: begin
          end_interrupt_next = end_interrupt_next | highest_level_in_service;
          if (highest_level_in_service != '0) rotate_next = level_of(highest_level_in_service);
        end
        3'b111: begin
          end_interrupt_next = end_interrupt_next | (NUM_IR'(1) << ocw2_data[2:0]);
          rotate_next        = ocw2_data[2:0];
        end
        3'b110: rotate_next = ocw2_data[2:0];
`ifdef AUTO_EOI_EN
        3'b100: aeoi_rotate_next = 1'b1;
        3'b000: aeoi_rotate_next = 1'b0;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      acked           <= '0;
      latch_ISR       <= 1'b0;
      interrupt       <= '0;
      clear_irr       <= '0;
      end_interrupt   <= '0;
      priority_rotate <= 3'd7;
      data_out        <= '0;
      data_out_en     <= 1'b0;
`ifdef AUTO_EOI_EN
      aeoi_due        <= 1'b0;
      aeoi_rotate     <= 1'b0;
`endif
    end else begin
      state           <= state_next;
      acked           <= acked_next;
      latch_ISR       <= latch_next;
      interrupt       <= interrupt_next;
      clear_irr       <= clear_irr_next;
      end_interrupt   <= end_interrupt_next;
      priority_rotate <= rotate_next;
      data_out        <= data_out_next;
      data_out_en     <= data_out_en_next;
`ifdef AUTO_EOI_EN
      aeoi_due        <= aeoi_due_next;
      aeoi_rotate     <= aeoi_rotate_next;
`endif
    end
  end

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed bench for pic_interrupt_sequencer; expectations follow AUTO_EOI_EN when defined.
module tb_pic_interrupt_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] request_highest, highest_level_in_service;
  logic       inta_pulse, ocw2_write;
  logic [7:0] ocw2_data;
  logic [4:0] vector_base;
  logic       int_out, latch_ISR, data_out_en;
  logic [7:0] interrupt, clear_irr, end_interrupt, data_out;
  logic [2:0] priority_rotate;

  int checks = 0;
  int failures = 0;

`ifdef AUTO_EOI_EN
  localparam bit AEOI = 1'b1;
`else
  localparam bit AEOI = 1'b0;
`endif

  pic_interrupt_sequencer #(.NUM_IR(8)) dut (
    .clk(clk), .reset(reset),
    .request_highest(request_highest),
    .highest_level_in_service(highest_level_in_service),
    .inta_pulse(inta_pulse), .ocw2_write(ocw2_write), .ocw2_data(ocw2_data),
    .vector_base(vector_base), .int_out(int_out), .interrupt(interrupt),
    .latch_ISR(latch_ISR), .clear_irr(clear_irr), .end_interrupt(end_interrupt),
    .priority_rotate(priority_rotate), .data_out(data_out), .data_out_en(data_out_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ocw2(input logic [7:0] d);
    ocw2_write = 1'b1; ocw2_data = d;
    tick();
    ocw2_write = 1'b0; ocw2_data = 8'h00;
  endtask

  task automatic inta();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
  endtask

  initial begin
    reset = 1'b1; request_highest = 8'h00; highest_level_in_service = 8'h00;
    inta_pulse = 1'b0; ocw2_write = 1'b0; ocw2_data = 8'h00; vector_base = 5'b01000;
    tick(); tick();
    chk("rst_int_out", {7'd0, int_out}, 8'h00);
    chk("rst_rotate", {5'd0, priority_rotate}, 8'h07);
    chk("rst_latch", {7'd0, latch_ISR}, 8'h00);
    chk("rst_data_en", {7'd0, data_out_en}, 8'h00);
    chk("rst_eoi", end_interrupt, 8'h00);
    reset = 1'b0;

    // Basic acknowledge of IR2
    request_highest = 8'h04;
    tick();
    chk("basic_int_out", {7'd0, int_out}, 8'h01);
    tick();
    chk("basic_int_hold", {7'd0, int_out}, 8'h01);
    inta();
    chk("basic_latch", {7'd0, latch_ISR}, 8'h01);
    chk("basic_interrupt", interrupt, 8'h04);
    chk("basic_clear_irr", clear_irr, 8'h04);
    chk("basic_int_drop", {7'd0, int_out}, 8'h00);
    tick();
    chk("basic_latch_1cyc", {7'd0, latch_ISR}, 8'h00);
    chk("basic_no_vec_yet", {7'd0, data_out_en}, 8'h00);
    inta();
    request_highest = 8'h00;
    chk("basic_data_en", {7'd0, data_out_en}, 8'h01);
    chk("basic_vector", data_out, 8'h42);
    tick();
    chk("basic_data_en_1cyc", {7'd0, data_out_en}, 8'h00);
    chk("basic_aeoi", end_interrupt, AEOI ? 8'h04 : 8'h00);
    tick();

    // Nested blocking: IR3 vs in-service IR1, rotate 7
    highest_level_in_service = 8'h02; request_highest = 8'h08;
    tick(); tick();
    chk("nest_blocked", {7'd0, int_out}, 8'h00);
    request_highest = 8'h01;
    tick();
    chk("nest_ir0_wins", {7'd0, int_out}, 8'h01);

    // Spurious: request withdrawn before first INTA
    request_highest = 8'h00;
    inta();
    chk("spur_no_latch", {7'd0, latch_ISR}, 8'h00);
    chk("spur_no_clear", clear_irr, 8'h00);
    inta();
    chk("spur_data_en", {7'd0, data_out_en}, 8'h01);
    chk("spur_vector", data_out, 8'h47);
    tick();
    chk("spur_no_aeoi", end_interrupt, 8'h00);
    tick();

    // Rotate on non-specific EOI
    highest_level_in_service = 8'h10;
    ocw2(8'hA0);
    chk("rot_eoi", end_interrupt, 8'h10);
    chk("rot_value", {5'd0, priority_rotate}, 8'h04);
    tick();
    chk("rot_eoi_1cyc", end_interrupt, 8'h00);
    request_highest = 8'h10; highest_level_in_service = 8'h20;
    tick(); tick();
    chk("rot_ir4_blocked", {7'd0, int_out}, 8'h00);
    request_highest = 8'h20; highest_level_in_service = 8'h10;
    tick();
    chk("rot_ir5_wins", {7'd0, int_out}, 8'h01);

    // Specific EOI of IR2 in the same cycle as first INTA for IR2
    request_highest = 8'h04;
    inta_pulse = 1'b1; ocw2_write = 1'b1; ocw2_data = 8'h62;
    tick();
    inta_pulse = 1'b0; ocw2_write = 1'b0; ocw2_data = 8'h00;
    chk("coll_interrupt", interrupt, 8'h04);
    chk("coll_latch", {7'd0, latch_ISR}, 8'h01);
    chk("coll_eoi", end_interrupt, 8'h04);

    // Reset while in ACK1
    reset = 1'b1;
    tick();
    reset = 1'b0; request_highest = 8'h00; highest_level_in_service = 8'h00;
    chk("mid_rst_int_out", {7'd0, int_out}, 8'h00);
    chk("mid_rst_latch", {7'd0, latch_ISR}, 8'h00);
    chk("mid_rst_eoi", end_interrupt, 8'h00);
    chk("mid_rst_rotate", {5'd0, priority_rotate}, 8'h07);
    inta();
    chk("mid_rst_idle", {7'd0, data_out_en}, 8'h00);

    // Set priority, non-specific EOI, rotate on specific EOI
    ocw2(8'hC3);
    chk("setpri_rotate", {5'd0, priority_rotate}, 8'h03);
    chk("setpri_no_eoi", end_interrupt, 8'h00);
    highest_level_in_service = 8'h02;
    ocw2(8'h20);
    chk("nseoi_eoi", end_interrupt, 8'h02);
    chk("nseoi_rotate", {5'd0, priority_rotate}, 8'h03);
    highest_level_in_service = 8'h00;
    ocw2(8'hE7);
    chk("rseoi_eoi", end_interrupt, 8'h80);
    chk("rseoi_rotate", {5'd0, priority_rotate}, 8'h07);
    ocw2(8'h80);
    chk("aeoi_rot_set_noop", end_interrupt, 8'h00);

    // Full IR6 cycle: automatic EOI (and rotate) only with AUTO_EOI_EN
    request_highest = 8'h40;
    tick();
    chk("ir6_int_out", {7'd0, int_out}, 8'h01);
    inta();
    chk("ir6_interrupt", interrupt, 8'h40);
    inta();
    request_highest = 8'h00;
    chk("ir6_vector", data_out, 8'h46);
    chk("ir6_eoi_early", end_interrupt, 8'h00);
    tick();
    chk("ir6_aeoi", end_interrupt, AEOI ? 8'h40 : 8'h00);
    chk("ir6_aeoi_rotate", {5'd0, priority_rotate}, AEOI ? 8'h06 : 8'h07);
    tick();
    chk("ir6_aeoi_1cyc", end_interrupt, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
